ddr_burst_arbiter: RTL and testbench

Sequences DDR3 burst transactions for the camera-to-HDMI frame buffer. Consumes the level requests from the write/read FIFO wrapper: Wr_req means the write-side FIFO holds at least one burst; Rd_req means the read-side FIFO has room for one burst. Grants one burst at a time to the AXI burst engine and generates burst addresses. Manages a two-buffer ping-pong frame store so that the display never reads the frame currently being written. Sits in the DDR user-clock domain between the FIFO wrapper and the AXI master.

---
 rtl/ddr_burst_arbiter_if.sv | 31 +++
 rtl/ddr_burst_arbiter.sv | 121 ++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_arbiter_if.sv
// Handshake bundle between the burst arbiter, the FIFO wrapper level requests
// and the AXI burst engine. The arbiter uses the master view.
interface ddr_burst_arbiter_if #(
    parameter int ADDR_WIDTH = 30
);
    logic                  Init_calib_complete;
    logic                  Wr_req;
    logic                  Rd_req;
    logic                  Rd_Start;
    logic                  Wr_burst_done;
    logic                  Rd_burst_done;
    logic                  Wr_burst_start;
    logic [ADDR_WIDTH-1:0] Wr_burst_addr;
    logic                  Rd_burst_start;
    logic [ADDR_WIDTH-1:0] Rd_burst_addr;
    logic                  Wr_frame_done;
    logic                  Rd_frame_done;
    logic                  Busy;

    modport master (
        input  Init_calib_complete, Wr_req, Rd_req, Rd_Start, Wr_burst_done, Rd_burst_done,
        output Wr_burst_start, Wr_burst_addr, Rd_burst_start, Rd_burst_addr,
               Wr_frame_done, Rd_frame_done, Busy
    );

    modport slave (
        output Init_calib_complete, Wr_req, Rd_req, Rd_Start, Wr_burst_done, Rd_burst_done,
        input  Wr_burst_start, Wr_burst_addr, Rd_burst_start, Rd_burst_addr,
               Wr_frame_done, Rd_frame_done, Busy
    );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// One-burst-at-a-time DDR3 arbiter for the camera-to-HDMI frame buffer:
// round-robin write/read grants, burst address generation, ping-pong buffers.
module ddr_burst_arbiter #(
    parameter int                    ADDR_WIDTH   = 30,
    parameter int                    BURST_LEN    = 240,
    parameter int                    BEAT_BYTES   = 16,
    parameter int                    FRAME_BURSTS = 1080,
    parameter logic [ADDR_WIDTH-1:0] BUF0_BASE    = '0,
    parameter logic [ADDR_WIDTH-1:0] BUF1_BASE    = ADDR_WIDTH'(32'h0080_0000)
) (
    input logic                 Sys_clk,
    input logic                 Rst,
    ddr_burst_arbiter_if.master bus
);
    localparam int CNT_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FRAME_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);

    typedef enum logic [2:0] {IDLE, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      wr_cnt, rd_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                  wr_buf, rd_buf, done_buf, frame_valid;
    logic                  last_grant_wr;
    logic                  wr_frame_done, rd_frame_done;

    logic wr_ok, rd_ok, wr_end, rd_end, wr_keep, rd_grant;

    function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic b);
        return b ? BUF1_BASE : BUF0_BASE;
    endfunction

    always_comb begin
        wr_ok     = bus.Init_calib_complete & bus.Wr_req;
        rd_ok     = bus.Init_calib_complete & bus.Rd_req & bus.Rd_Start & frame_valid;
        wr_end    = (state == WR_WAIT) & bus.Wr_burst_done;
        rd_end    = (state == RD_WAIT) & bus.Rd_burst_done;
        // Toggling would land the writer on the buffer the reader is mid-frame in.
        wr_keep   = (rd_cnt != '0) && (rd_buf != wr_buf);
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_ok && (!rd_ok || !last_grant_wr)) state_nxt = WR_CMD;
                else if (rd_ok)                          state_nxt = RD_CMD;
            end
            WR_CMD:  state_nxt = WR_WAIT;
            WR_WAIT: if (bus.Wr_burst_done) state_nxt = IDLE;
            RD_CMD:  state_nxt = RD_WAIT;
            RD_WAIT: if (bus.Rd_burst_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        rd_grant = (state == IDLE) && (state_nxt == RD_CMD);
    end

    always_ff @(posedge Sys_clk) begin
        if (Rst) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            wr_addr       <= BUF0_BASE;
            rd_addr       <= BUF0_BASE;
            wr_buf        <= 1'b0;
            rd_buf        <= 1'b0;
            done_buf      <= 1'b0;
            frame_valid   <= 1'b0;
            last_grant_wr <= 1'b0;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
            if (state == WR_CMD) last_grant_wr <= 1'b1;
            if (state == RD_CMD) last_grant_wr <= 1'b0;

            if (wr_end) begin
                if (wr_cnt == CNT_LAST) begin
                    wr_cnt        <= '0;
                    wr_frame_done <= 1'b1;
                    frame_valid   <= 1'b1;
                    done_buf      <= wr_buf;
                    if (wr_keep) begin
                        wr_addr <= buf_base(wr_buf);
                    end else begin
                        wr_buf  <= ~wr_buf;
                        wr_addr <= buf_base(~wr_buf);
                    end
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                    wr_addr <= wr_addr + STEP;
                end
            end

            // A new read frame always starts on the most recently completed buffer.
            if (rd_grant && (rd_cnt == '0)) begin
                rd_buf  <= done_buf;
                rd_addr <= buf_base(done_buf);
            end

            if (rd_end) begin
                if (rd_cnt == CNT_LAST) begin
                    rd_cnt        <= '0;
                    rd_frame_done <= 1'b1;
                    rd_addr       <= buf_base(rd_buf);
                end else begin
                    rd_cnt  <= rd_cnt + 1'b1;
                    rd_addr <= rd_addr + STEP;
                end
            end
        end
    end

    assign bus.Wr_burst_start = (state == WR_CMD);
    assign bus.Rd_burst_start = (state == RD_CMD);
    assign bus.Wr_burst_addr  = wr_addr;
    assign bus.Rd_burst_addr  = rd_addr;
    assign bus.Wr_frame_done  = wr_frame_done;
    assign bus.Rd_frame_done  = rd_frame_done;
    assign bus.Busy           = (state != IDLE);
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Bench for ddr_burst_arbiter: randomized FIFO requests and AXI completions,
// frame-level reference model, scoreboard monitor on the negative clock edge.
module tb_ddr_burst_arbiter;
    localparam int AW = 30;
    localparam int FB = 4;
    localparam logic [AW-1:0] B0   = 30'h0;
    localparam logic [AW-1:0] B1   = 30'h0080_0000;
    localparam logic [AW-1:0] STEP = 30'd3840;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_burst_arbiter_if #(.ADDR_WIDTH(AW)) bus();

    ddr_burst_arbiter #(
        .ADDR_WIDTH(AW), .BURST_LEN(240), .BEAT_BYTES(16), .FRAME_BURSTS(FB),
        .BUF0_BASE(B0), .BUF1_BASE(B1)
    ) dut (
        .Sys_clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: frame-level bookkeeping of the ping-pong store
    int m_wr_cnt, m_rd_cnt;
    bit m_wr_buf, m_rd_buf, m_done_buf, m_fv;
    int wfd_q[$];
    int rfd_q[$];
    int n_wr_frames = 0;

    // Responder / monitor state
    bit wr_out, rd_out, inject, alt_chk;
    int wr_dly, rd_dly, last_done_cyc;
    bit mon_wr_act, mon_rd_act, last_kind_rd;
    logic [AW-1:0] mon_wr_addr, mon_rd_addr;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [AW-1:0] base(input bit b);
        return b ? B1 : B0;
    endfunction

    function automatic logic [AW-1:0] exp_wr_addr();
        return base(m_wr_buf) + AW'(m_wr_cnt) * STEP;
    endfunction

    function automatic logic [AW-1:0] exp_rd_addr();
        return base(m_rd_buf) + AW'(m_rd_cnt) * STEP;
    endfunction

    function automatic void model_reset();
        m_wr_cnt = 0; m_rd_cnt = 0;
        m_wr_buf = 0; m_rd_buf = 0; m_done_buf = 0; m_fv = 0;
        wfd_q.delete(); rfd_q.delete();
        mon_wr_act = 0; mon_rd_act = 0;
    endfunction

    function automatic void model_wr_done();
        m_wr_cnt++;
        if (m_wr_cnt == FB) begin
            m_wr_cnt   = 0;
            m_fv       = 1;
            m_done_buf = m_wr_buf;
            // Drop policy: never move onto the buffer a reader is halfway through.
            if (!(m_rd_cnt != 0 && m_rd_buf == !m_wr_buf)) m_wr_buf = !m_wr_buf;
            wfd_q.push_back(cyc + 1);
            n_wr_frames++;
        end
    endfunction

    function automatic void model_rd_done();
        m_rd_cnt++;
        if (m_rd_cnt == FB) begin
            m_rd_cnt = 0;
            rfd_q.push_back(cyc + 1);
        end
    endfunction

    // One clock of stimulus: AXI-engine responder plus optional stray done pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.Wr_burst_done = 1'b0;
        bus.Rd_burst_done = 1'b0;
        if (bus.Wr_burst_start) begin
            wr_out = 1; wr_dly = $urandom_range(0, 3);
        end else if (wr_out) begin
            if (wr_dly == 0) begin
                bus.Wr_burst_done = 1'b1; wr_out = 0; last_done_cyc = cyc; model_wr_done();
            end else wr_dly--;
        end
        if (bus.Rd_burst_start) begin
            rd_out = 1; rd_dly = $urandom_range(0, 3);
        end else if (rd_out) begin
            if (rd_dly == 0) begin
                bus.Rd_burst_done = 1'b1; rd_out = 0; last_done_cyc = cyc; model_rd_done();
            end else rd_dly--;
        end
        if (inject) begin
            if (!wr_out && !bus.Wr_burst_done && $urandom_range(0, 5) == 0) bus.Wr_burst_done = 1'b1;
            if (!rd_out && !bus.Rd_burst_done && $urandom_range(0, 5) == 0) bus.Rd_burst_done = 1'b1;
        end
    endtask

    task automatic wait_start(input bit rd, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(rd ? bus.Rd_burst_start : bus.Wr_burst_start) && n < 100);
        check(nm, rd ? bus.Rd_burst_start : bus.Wr_burst_start, 1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            mon_wr_act = 0;
            mon_rd_act = 0;
        end else begin
            check("single_grant", bus.Wr_burst_start & bus.Rd_burst_start, 0);
            if (bus.Wr_burst_start) begin
                check("wr_addr", bus.Wr_burst_addr, exp_wr_addr());
                check("wr_busy", bus.Busy, 1);
                if (alt_chk) begin
                    check("alt_after_rd", last_kind_rd, 1);
                    check("wr_spacing", cyc - last_done_cyc, 2);
                end
                last_kind_rd = 0; mon_wr_act = 1; mon_wr_addr = exp_wr_addr();
            end else if (mon_wr_act) begin
                check("wr_addr_hold", bus.Wr_burst_addr, mon_wr_addr);
                if (bus.Wr_burst_done) mon_wr_act = 0;
            end
            if (bus.Rd_burst_start) begin
                check("rd_needs_frame", m_fv, 1);
                if (m_rd_cnt == 0) m_rd_buf = m_done_buf;
                check("rd_addr", bus.Rd_burst_addr, exp_rd_addr());
                check("rd_busy", bus.Busy, 1);
                if (alt_chk) begin
                    check("alt_after_wr", last_kind_rd, 0);
                    check("rd_spacing", cyc - last_done_cyc, 2);
                end
                last_kind_rd = 1; mon_rd_act = 1; mon_rd_addr = exp_rd_addr();
            end else if (mon_rd_act) begin
                check("rd_addr_hold", bus.Rd_burst_addr, mon_rd_addr);
                if (bus.Rd_burst_done) mon_rd_act = 0;
            end
            if (bus.Wr_frame_done) begin
                if (wfd_q.size() == 0) check("wr_frame_done_extra", bus.Wr_frame_done, 0);
                else check("wr_frame_done_cyc", cyc, wfd_q.pop_front());
            end else if (wfd_q.size() != 0 && wfd_q[0] <= cyc) begin
                check("wr_frame_done_missing", bus.Wr_frame_done, 1);
                void'(wfd_q.pop_front());
            end
            if (bus.Rd_frame_done) begin
                if (rfd_q.size() == 0) check("rd_frame_done_extra", bus.Rd_frame_done, 0);
                else check("rd_frame_done_cyc", cyc, rfd_q.pop_front());
            end else if (rfd_q.size() != 0 && rfd_q[0] <= cyc) begin
                check("rd_frame_done_missing", bus.Rd_frame_done, 1);
                void'(rfd_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int f;
        bus.Init_calib_complete = 1'b0;
        bus.Wr_req = 1'b1; bus.Rd_req = 1'b0; bus.Rd_Start = 1'b0;
        bus.Wr_burst_done = 1'b0; bus.Rd_burst_done = 1'b0;
        inject = 0; alt_chk = 0; wr_out = 0; rd_out = 0; last_done_cyc = 0; last_kind_rd = 0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        // Reset state and calibration gating
        for (int i = 0; i < 4; i++) begin
            tick();
            check("precal_no_grant", bus.Wr_burst_start, 0);
            check("reset_busy", bus.Busy, 0);
            check("reset_wr_addr", bus.Wr_burst_addr, B0);
            check("reset_rd_addr", bus.Rd_burst_addr, B0);
            check("reset_frame_pulses", {bus.Wr_frame_done, bus.Rd_frame_done}, 0);
        end
        bus.Init_calib_complete = 1'b1;
        tick();
        check("calib_latency", bus.Wr_burst_start, 1);
        check("first_wr_addr", bus.Wr_burst_addr, B0);
        wait_start(0, "second_wr_start");
        check("second_wr_addr", bus.Wr_burst_addr, 30'hF00);

        // Reads requested before any frame exists; alternation once one does
        bus.Rd_req = 1'b1; bus.Rd_Start = 1'b1;
        n = 0;
        while (n_wr_frames == 0 && n < 300) begin tick(); n++; end
        check("first_frame_written", n_wr_frames, 1);
        alt_chk = 1;
        wait_start(1, "first_rd_start");
        check("first_rd_addr", bus.Rd_burst_addr, B0);
        wait_start(0, "fifth_wr_start");
        check("fifth_wr_addr", bus.Wr_burst_addr, B1);
        repeat (80) tick();
        alt_chk = 0;

        // Writer finishes a frame while the reader is mid-frame on the other buffer
        n = 0;
        while (!(m_rd_buf && (m_rd_cnt inside {[1:2]}) && !m_wr_buf) && n < 800) begin tick(); n++; end
        bus.Rd_req = 1'b0;
        f = n_wr_frames;
        n = 0;
        while (n_wr_frames == f && n < 300) begin tick(); n++; end
        check("drop_frame_written", n_wr_frames, f + 1);
        wait_start(0, "drop_wr_start");
        check("drop_wr_stays_buf0", bus.Wr_burst_addr, B0);
        bus.Rd_req = 1'b1;
        wait_start(1, "drop_rd_start");
        check("drop_rd_stays_buf1", bus.Rd_burst_addr >= B1, 1);

        // Randomized request levels with stray done pulses
        inject = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.Wr_req = !bus.Wr_req;
            if ($urandom_range(0, 7) == 0) bus.Rd_req = !bus.Rd_req;
            tick();
        end
        inject = 0;

        // Reset in the middle of a write burst, then a stale done pulse
        bus.Rd_req = 1'b0; bus.Wr_req = 1'b1;
        wait_start(0, "rst_pre_start");
        tick();
        bus.Wr_req = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_busy", bus.Busy, 0);
        check("rst_wr_addr", bus.Wr_burst_addr, B0);
        check("rst_rd_addr", bus.Rd_burst_addr, B0);
        rst = 1'b0;
        model_reset();
        wr_out = 0; rd_out = 0;
        bus.Wr_burst_done = 1'b1;
        tick();
        check("late_done_busy", bus.Busy, 0);
        bus.Wr_req = 1'b1;
        wait_start(0, "post_rst_start");
        check("late_done_ignored", bus.Wr_burst_addr, B0);
        wait_start(0, "post_rst_second");
        check("post_rst_second_addr", bus.Wr_burst_addr, 30'hF00);

        // Drain
        bus.Wr_req = 1'b0; bus.Rd_req = 1'b0;
        repeat (30) tick();
        check("wr_frame_done_pending", wfd_q.size(), 0);
        check("rd_frame_done_pending", rfd_q.size(), 0);
        check("idle_at_end", bus.Busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
